// File: rtl/key_press_classifier_if.sv
// Button-side signal bundle for key_press_classifier.
// The master drives the raw pin and the slave returns the debounced level and the classification pulses.
interface key_press_classifier_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic hold_long;

    modport master (
        output btn_in,
        input  btn_level, press_pulse, short_pulse, long_pulse, hold_long
    );

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, short_pulse, long_pulse, hold_long
    );
endinterface

// File: rtl/key_press_classifier.sv
// Synchronizes, debounces and classifies one push-button: press edge, short release, long hold.
// Latency: btn_level and press_pulse follow btn_in after 2+DB_CYCLES edges; no backpressure, all outputs are registered.
module key_press_classifier #(
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 100000000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    key_press_classifier_if.slave io_btn
);
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [1:0]        r_sync;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_level;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press;
    logic              r_short;
    logic              r_long;
    logic              r_hold_long;

    logic              w_s;
    logic              w_level_nxt;
    logic [DB_W-1:0]   w_db_cnt_nxt;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              w_press_nxt;
    logic              w_short_nxt;
    logic              w_long_nxt;
    logic              w_hold_long_nxt;

    // Polarity is corrected before the synchronizer so both flops reset to the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], io_btn.btn_in ^ ACTIVE_LOW};
    end

    assign w_s = r_sync[1];

    always_comb begin
        w_level_nxt  = r_level;
        w_db_cnt_nxt = '0;
        if (w_s != r_level) begin
            if (r_db_cnt == DB_LAST) w_level_nxt  = w_s;
            else                     w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
    end

    // The classifier looks at the next level so press/short pulses land on the btn_level edge itself.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_press_nxt     = 1'b0;
        w_short_nxt     = 1'b0;
        w_long_nxt      = 1'b0;
        w_hold_long_nxt = r_hold_long;
        case (r_state)
            IDLE: begin
                if (w_level_nxt && !r_level) begin
                    w_state_nxt    = HELD;
                    w_press_nxt    = 1'b1;
                    w_hold_cnt_nxt = HOLD_W'(1);
                end
            end
            HELD: begin
                if (!w_level_nxt) begin
                    w_state_nxt    = IDLE;
                    w_short_nxt    = 1'b1;
                    w_hold_cnt_nxt = '0;
                end else if (r_hold_cnt == HOLD_MAX) begin
                    w_state_nxt     = LONG;
                    w_long_nxt      = 1'b1;
                    w_hold_long_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                if (!w_level_nxt) begin
                    w_state_nxt     = IDLE;
                    w_hold_long_nxt = 1'b0;
                    w_hold_cnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_hold_cnt_nxt  = '0;
                w_hold_long_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt    <= '0;
            r_level     <= 1'b0;
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_press     <= 1'b0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
            r_hold_long <= 1'b0;
        end else begin
            r_db_cnt    <= w_db_cnt_nxt;
            r_level     <= w_level_nxt;
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_press     <= w_press_nxt;
            r_short     <= w_short_nxt;
            r_long      <= w_long_nxt;
            r_hold_long <= w_hold_long_nxt;
        end
    end

    assign io_btn.btn_level   = r_level;
    assign io_btn.press_pulse = r_press;
    assign io_btn.short_pulse = r_short;
    assign io_btn.long_pulse  = r_long;
    assign io_btn.hold_long   = r_hold_long;
endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with DB_CYCLES=4, LONG_CYCLES=20, active-high and active-low instances.
module tb_key_press_classifier;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    key_press_classifier_if a_if ();
    key_press_classifier_if b_if ();

    key_press_classifier #(.DB_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .io_btn(a_if.slave)
    );
    key_press_classifier #(.DB_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)) u_dut_low (
        .clk(clk), .rst(rst2), .io_btn(b_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event tallies sampled mid-cycle; only observations, never expectations.
    int n_press = 0, n_short = 0, n_long = 0, n_multi = 0;
    int n2_press = 0, n2_short = 0, n2_long = 0;
    int press_cyc = 0, long_cyc = 0;
    always @(negedge clk) begin
        if (a_if.press_pulse) begin n_press++; press_cyc = cyc; end
        if (a_if.short_pulse) n_short++;
        if (a_if.long_pulse)  begin n_long++; long_cyc = cyc; end
        if (32'(a_if.press_pulse) + 32'(a_if.short_pulse) + 32'(a_if.long_pulse) > 1) n_multi++;
        if (b_if.press_pulse) n2_press++;
        if (b_if.short_pulse) n2_short++;
        if (b_if.long_pulse)  n2_long++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, a_if.btn_level, a_if.press_pulse, a_if.short_pulse,
                    a_if.long_pulse, a_if.hold_long}, {27'd0, exp});
    endtask

    int bp, bs, bl;

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        a_if.btn_in = 1'b0;
        b_if.btn_in = 1'b1;
        tick(3);
        check_outs("reset_outputs", 5'b00000);
        check("reset_level_low", {31'd0, b_if.btn_level}, 32'd0);
        rst = 1'b0;
        rst2 = 1'b0;

        // Active-low instance idles with the pin high: nothing may come out.
        tick(30);
        check("low_idle_press", n2_press, 0);
        check("low_idle_short", n2_short + n2_long, 0);
        check("low_idle_level", {31'd0, b_if.btn_level}, 32'd0);
        b_if.btn_in = 1'b0;
        tick(5);
        check("low_level_edge5", {31'd0, b_if.btn_level}, 32'd0);
        tick(1);
        check("low_press_edge6", {30'd0, b_if.btn_level, b_if.press_pulse}, 32'd3);
        b_if.btn_in = 1'b1;
        tick(6);
        check("low_short_edge6", {31'd0, b_if.short_pulse}, 32'd1);
        tick(4);

        // Clean 10-cycle press.
        bp = n_press; bs = n_short; bl = n_long;
        a_if.btn_in = 1'b1;
        tick(5);
        check_outs("clean_edge5", 5'b00000);
        tick(1);
        check_outs("clean_press_edge6", 5'b11000);
        tick(1);
        check_outs("clean_press_gone", 5'b10000);
        tick(3);
        a_if.btn_in = 1'b0;
        tick(5);
        check_outs("clean_rel_edge5", 5'b10000);
        tick(1);
        check_outs("clean_short_edge6", 5'b00100);
        tick(1);
        check_outs("clean_short_gone", 5'b00000);
        check("clean_counts", {8'd0, 8'(n_press - bp), 8'(n_short - bs), 8'(n_long - bl)}, 32'h00010100);

        // 40-cycle hold reaching the long threshold.
        tick(3);
        bp = n_press; bs = n_short; bl = n_long;
        a_if.btn_in = 1'b1;
        tick(6);
        check_outs("long_press", 5'b11000);
        tick(19);
        check_outs("long_before", 5'b10000);
        tick(1);
        check_outs("long_pulse", 5'b10011);
        tick(1);
        check_outs("long_hold", 5'b10001);
        tick(13);
        a_if.btn_in = 1'b0;
        tick(5);
        check_outs("long_rel_edge5", 5'b10001);
        tick(1);
        check_outs("long_released", 5'b00000);
        tick(2);
        check("long_counts", {8'd0, 8'(n_press - bp), 8'(n_short - bs), 8'(n_long - bl)}, 32'h00010001);
        check("long_distance", long_cyc - press_cyc, 20);

        // Bounce: toggle every 2 cycles for 30 cycles, ending high.
        tick(3);
        bp = n_press; bs = n_short;
        for (int i = 0; i < 15; i++) begin
            a_if.btn_in = (i % 2 == 0);
            if (i < 14) tick(2);
        end
        tick(5);
        check("bounce_quiet", {8'(n_press - bp), 8'(n_short - bs), 15'd0, a_if.btn_level}, 32'd0);
        tick(1);
        check_outs("bounce_press", 5'b11000);
        a_if.btn_in = 1'b0;
        tick(8);
        check("bounce_press_count", n_press - bp, 1);

        // Reset in the middle of a held press.
        tick(3);
        a_if.btn_in = 1'b1;
        tick(16);
        check_outs("mid_held", 5'b10000);
        rst = 1'b1;
        #1;
        check_outs("mid_async_reset", 5'b00000);
        tick(3);
        check_outs("mid_in_reset", 5'b00000);
        rst = 1'b0;
        bp = n_press;
        tick(5);
        check_outs("mid_edge5", 5'b00000);
        tick(1);
        check_outs("mid_press", 5'b11000);
        tick(19);
        check_outs("mid_before_long", 5'b10000);
        tick(1);
        check_outs("mid_long", 5'b10011);
        a_if.btn_in = 1'b0;
        tick(10);

        // 3-cycle glitch stays below the debounce threshold.
        bp = n_press;
        a_if.btn_in = 1'b1;
        tick(3);
        a_if.btn_in = 1'b0;
        tick(10);
        check_outs("glitch_outputs", 5'b00000);
        check("glitch_press", n_press - bp, 0);

        check("pulses_exclusive", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
